// File: rtl/wb_burst_master.sv
// Wishbone burst master: issues incrementing write bursts or read-and-compare bursts
// with a seed+k data pattern, per-beat ack timeout and saturating mismatch counter.
module wb_burst_master #(
    parameter int unsigned dw     = 32,
    parameter int unsigned APP_AW = 26,
    parameter int unsigned TMO    = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [APP_AW-1:0]   cmd_addr_i,
    input  logic [7:0]          cmd_len_i,
    input  logic [dw-1:0]       cmd_seed_i,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [APP_AW-1:0]   wb_adr_o,
    output logic [dw/8-1:0]     wb_sel_o,
    output logic [dw-1:0]       wb_dat_o,
    output logic [2:0]          wb_cti_o,
    input  logic [dw-1:0]       wb_dat_i,
    input  logic                wb_ack_i,
    output logic [dw-1:0]       rd_data_o,
    output logic                rd_valid_o,
    output logic                done_o,
    output logic [15:0]         err_cnt_o,
    output logic                timeout_o
);

    localparam int unsigned SW = dw / 8;
    localparam logic [2:0] CTI_INC = 3'b010;
    localparam logic [2:0] CTI_END = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE} state_e;

    state_e state_q, state_d;

    logic              we_l_q, we_l_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        beat_q, beat_d;
    logic [APP_AW-1:0] adr_q, adr_d;
    logic [dw-1:0]     dat_q, dat_d;
    logic [15:0]       wait_q, wait_d;
    logic [15:0]       err_q, err_d;
    logic              tmo_q, tmo_d;
    logic [dw-1:0]     rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic [2:0]        cti_q, cti_d, cti_n;

    logic accept, last_beat, tmo_hit;

    assign accept    = (state_q == S_IDLE) && cmd_valid_i;
    assign last_beat = (8'(beat_q + 8'd1) == len_q);
    assign tmo_hit   = (16'(wait_q + 16'd1) >= 16'(TMO));

    // State register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = (cmd_len_i == 8'd0) ? S_DONE : S_BURST;
            S_BURST: begin
                if (wb_ack_i) begin
                    if (last_beat) state_d = S_DONE;
                end else if (tmo_hit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        we_l_d     = we_l_q;
        len_d      = len_q;
        beat_d     = beat_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        wait_d     = wait_q;
        err_d      = err_q;
        tmo_d      = tmo_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        cti_n      = cti_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_l_d = cmd_we_i;
                    len_d  = cmd_len_i;
                    beat_d = 8'd0;
                    adr_d  = cmd_addr_i;
                    dat_d  = cmd_seed_i;
                    wait_d = 16'd0;
                    cti_n  = (cmd_len_i == 8'd1) ? CTI_END : CTI_INC;
                end
            end
            S_BURST: begin
                if (wb_ack_i) begin
                    beat_d = 8'(beat_q + 8'd1);
                    adr_d  = APP_AW'(adr_q + APP_AW'(SW));
                    dat_d  = dw'(dat_q + dw'(1));
                    wait_d = 16'd0;
                    cti_n  = ((9'(beat_q) + 9'd2) == 9'(len_q)) ? CTI_END : CTI_INC;
                    if (!we_l_q) begin
                        rd_data_d  = wb_dat_i;
                        rd_valid_d = 1'b1;
                        if ((wb_dat_i != dat_q) && (err_q != 16'hFFFF))
                            err_d = 16'(err_q + 16'd1);
                    end
                end else begin
                    wait_d = 16'(wait_q + 16'd1);
                    if (tmo_hit) tmo_d = 1'b1;
                end
            end
            default: ;
        endcase
        cyc_d   = (state_d == S_BURST);
        we_d    = cyc_d & we_l_d;
        sel_d   = cyc_d ? {SW{1'b1}} : {SW{1'b0}};
        cti_d   = cyc_d ? cti_n : 3'b000;
        done_d  = (state_d == S_DONE);
        ready_d = (state_d == S_IDLE);
    end

    // Datapath registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            we_l_q     <= 1'b0;
            len_q      <= '0;
            beat_q     <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            wait_q     <= '0;
            err_q      <= '0;
            tmo_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            cti_q      <= '0;
        end else begin
            we_l_q     <= we_l_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            wait_q     <= wait_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            cti_q      <= cti_d;
        end
    end

    assign cmd_ready_o = ready_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_we_o     = we_q;
    assign wb_adr_o    = adr_q;
    assign wb_sel_o    = sel_q;
    assign wb_dat_o    = dat_q;
    assign wb_cti_o    = cti_q;
    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign done_o      = done_q;
    assign err_cnt_o   = err_q;
    assign timeout_o   = tmo_q;

endmodule
